// File: rtl/if_stage_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_stage_pkg;

  localparam int          LEN_WORD_DEF = 32;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/if_stage_id_reg.sv
// IF/ID pipeline register: instruction, fetch address + 4, valid flag.
// Latency: 1 cycle from load/bubble request to output.
// Backpressure: holds contents whenever neither load nor bubble is asserted.
module if_id_register
  import if_stage_pkg::*;
#(
  parameter int LEN_WORD = LEN_WORD_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic                i_bubble,
  input  logic [LEN_WORD-1:0] i_instruction,
  input  logic [LEN_WORD-1:0] i_inced_pc,
  output logic [LEN_WORD-1:0] o_instruction,
  output logic [LEN_WORD-1:0] o_inced_pc,
  output logic                o_valid
);

  // Bubble wins over load so a redirect can never leak a wrong-path instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_instruction <= LEN_WORD'(NOP);
      o_inced_pc    <= '0;
      o_valid       <= 1'b0;
    end else if (i_bubble) begin
      o_instruction <= LEN_WORD'(NOP);
      o_inced_pc    <= '0;
      o_valid       <= 1'b0;
    end else if (i_load) begin
      o_instruction <= i_instruction;
      o_inced_pc    <= i_inced_pc;
      o_valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: owns PC, fetches over req/ready, feeds IF/ID; IF_PERF_CNT_EN adds fetch/bubble counters.
// Latency: instruction appears on instruction_id one cycle after its ready cycle; zero-bubble streaming.
// Backpressure: stall freezes PC and IF/ID; data returned under stall is parked in a one-entry hold buffer.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                  LEN_WORD = LEN_WORD_DEF,
  parameter logic [LEN_WORD-1:0] PC_RESET = LEN_WORD'(PC_RESET_DEF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                pc_src,
  input  logic [LEN_WORD-1:0] jump_pc,
  output logic                imem_req,
  output logic [LEN_WORD-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [LEN_WORD-1:0] imem_rdata,
  output logic [LEN_WORD-1:0] instruction_id,
  output logic [LEN_WORD-1:0] inced_pc_id,
  output logic                valid_id
`ifdef IF_PERF_CNT_EN
  ,
  output logic [LEN_WORD-1:0] fetch_count,
  output logic [LEN_WORD-1:0] bubble_count
`endif
);

  state_t              r_state;
  logic [LEN_WORD-1:0] r_pc;
  logic [LEN_WORD-1:0] r_buf;

  state_t              w_state_next;
  logic [LEN_WORD-1:0] w_pc_next;
  logic [LEN_WORD-1:0] w_pc_inc;
  logic [LEN_WORD-1:0] w_jump_aligned;
  logic [LEN_WORD-1:0] w_load_dat;
  logic                w_load;
  logic                w_bubble;
  logic                w_buf_en;

  assign w_pc_inc       = r_pc + LEN_WORD'(PC_INC);
  assign w_jump_aligned = jump_pc & ~LEN_WORD'(3);
  assign imem_req       = (r_state == ST_FETCH);
  assign imem_addr      = r_pc;

  // Next-state / IF/ID control; stall masks pc_src, redirect overrides both states.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_bubble     = 1'b0;
    w_buf_en     = 1'b0;
    w_load_dat   = imem_rdata;
    if (!stall && pc_src) begin
      w_bubble     = 1'b1;
      w_pc_next    = w_jump_aligned;
      w_state_next = ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ready) begin
            if (stall) begin
              w_buf_en     = 1'b1;
              w_state_next = ST_HOLD;
            end else begin
              w_load    = 1'b1;
              w_pc_next = w_pc_inc;
            end
          end else if (!stall) begin
            w_bubble = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            w_load       = 1'b1;
            w_load_dat   = r_buf;
            w_pc_next    = w_pc_inc;
            w_state_next = ST_FETCH;
          end
        end
        default: w_state_next = ST_FETCH;
      endcase
    end
  end

  // PC, FSM state and hold buffer; reset drops any in-flight fetch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_FETCH;
      r_pc    <= PC_RESET;
      r_buf   <= LEN_WORD'(NOP);
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_buf_en) r_buf <= imem_rdata;
    end
  end

  if_id_register #(.LEN_WORD(LEN_WORD)) u_if_id (
    .clk           (clk),
    .reset         (reset),
    .i_load        (w_load),
    .i_bubble      (w_bubble),
    .i_instruction (w_load_dat),
    .i_inced_pc    (w_pc_inc),
    .o_instruction (instruction_id),
    .o_inced_pc    (inced_pc_id),
    .o_valid       (valid_id)
  );

`ifdef IF_PERF_CNT_EN
  logic [LEN_WORD-1:0] r_fetch_count;
  logic [LEN_WORD-1:0] r_bubble_count;

  // Saturating counts of valid loads and bubble loads into IF/ID.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_count  <= '0;
      r_bubble_count <= '0;
    end else begin
      if (w_load && !w_bubble && (r_fetch_count != '1)) r_fetch_count <= r_fetch_count + 1'b1;
      if (w_bubble && (r_bubble_count != '1)) r_bubble_count <= r_bubble_count + 1'b1;
    end
  end

  assign fetch_count  = r_fetch_count;
  assign bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, pc_src, imem_ready;
  logic [31:0] jump_pc, imem_rdata;

  logic        imem_req, valid_id;
  logic [31:0] imem_addr, instruction_id, inced_pc_id;
  logic        imem_req2, valid_id2;
  logic [31:0] imem_addr2, instruction_id2, inced_pc_id2;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count, bubble_count, fetch_count2, bubble_count2;
`endif

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] inc;
    logic        vld;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;

  always #5 clk = ~clk;

  if_stage #(.LEN_WORD(32), .PC_RESET(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src), .jump_pc(jump_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction_id(instruction_id), .inced_pc_id(inced_pc_id), .valid_id(valid_id)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
  );

  if_stage #(.LEN_WORD(32), .PC_RESET(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src), .jump_pc(jump_pc),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction_id(instruction_id2), .inced_pc_id(inced_pc_id2), .valid_id(valid_id2)
`ifdef IF_PERF_CNT_EN
    , .fetch_count(fetch_count2), .bubble_count(bubble_count2)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic drive(input logic rdy, input logic stl, input logic psrc,
                       input logic [31:0] jpc, input logic [31:0] rd);
    imem_ready = rdy;
    stall      = stl;
    pc_src     = psrc;
    jump_pc    = jpc;
    imem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = load instruction fetched at addr, 1 = bubble, 2 = hold previous
  task automatic push_exp(input int kind, input logic [31:0] addr);
    exp_t e;
    if (kind == 0)      e = '{ins: word(addr), inc: addr + 32'd4, vld: 1'b1};
    else if (kind == 1) e = '{ins: 32'h0, inc: 32'h0, vld: 1'b0};
    else                e = last_e;
    exp_q.push_back(e);
    last_e = e;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_q.delete();
    last_e = '0;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h1111_2222);
    reset = 1'b0;
    step();
    step();
    vectors++;
    if ({instruction_id, inced_pc_id, valid_id} !== 65'h0) begin
      errors++;
      $display("FAIL reset.ifid got %h/%h/%b want 0/0/0", instruction_id, inced_pc_id, valid_id);
    end
    vectors++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset.fetch got addr %h req %b want 0 1", imem_addr, imem_req);
    end
    vectors++;
    if (imem_addr2 !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL reset.pc_reset got %h want fffffffc", imem_addr2);
    end
    reset = 1'b1;
    exp_q.delete();
    last_e = '0;
  endtask

  task automatic test_stream();
    logic        rdy[6] = '{1, 1, 1, 0, 0, 1};
    logic        stl[6] = '{0, 0, 0, 1, 0, 0};
    logic [31:0] ea[6]  = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12};
    int          knd[6] = '{0, 0, 0, 2, 1, 0};
    exp_t        e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (imem_addr !== ea[i] || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL stream.fetch[%0d] got %h/%b want %h/1", i, imem_addr, imem_req, ea[i]);
      end
      drive(rdy[i], stl[i], 1'b0, 32'h0, rdy[i] ? word(ea[i]) : 32'hBAD0_BAD0);
      push_exp(knd[i], ea[i]);
      step();
      e = exp_q.pop_front();
      vectors++;
      if ({instruction_id, inced_pc_id, valid_id} !== e) begin
        errors++;
        $display("FAIL stream.ifid[%0d] got %h/%h/%b want %h/%h/%b", i,
                 instruction_id, inced_pc_id, valid_id, e.ins, e.inc, e.vld);
      end
    end
    vectors++;
    if (imem_addr !== 32'd16) begin
      errors++;
      $display("FAIL stream.end_addr got %h want 10", imem_addr);
    end
  endtask

  task automatic test_stall_hold();
    logic        rdy[7] = '{1, 1, 1, 1, 1, 0, 1};
    logic        stl[7] = '{0, 0, 1, 1, 1, 0, 0};
    logic        er[7]  = '{1, 1, 1, 0, 0, 0, 1};
    logic [31:0] ea[7]  = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd8, 32'd8, 32'd12};
    int          knd[7] = '{0, 0, 2, 2, 2, 0, 0};
    exp_t        e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (imem_addr !== ea[i] || imem_req !== er[i]) begin
        errors++;
        $display("FAIL stall.fetch[%0d] got %h/%b want %h/%b", i, imem_addr, imem_req, ea[i], er[i]);
      end
      drive(rdy[i], stl[i], 1'b0, 32'h0, (er[i] && rdy[i]) ? word(ea[i]) : 32'hDEAD_BEEF);
      push_exp(knd[i], ea[i]);
      step();
      e = exp_q.pop_front();
      vectors++;
      if ({instruction_id, inced_pc_id, valid_id} !== e) begin
        errors++;
        $display("FAIL stall.ifid[%0d] got %h/%h/%b want %h/%h/%b", i,
                 instruction_id, inced_pc_id, valid_id, e.ins, e.inc, e.vld);
      end
    end
    vectors++;
    if (imem_addr !== 32'd16) begin
      errors++;
      $display("FAIL stall.end_addr got %h want 10", imem_addr);
    end
  endtask

  task automatic test_redirect();
    logic        psrc[3] = '{0, 1, 0};
    logic [31:0] ea[3]   = '{32'h0, 32'h4, 32'h40};
    int          knd[3]  = '{0, 1, 0};
    exp_t        e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (imem_addr !== ea[i]) begin
        errors++;
        $display("FAIL redirect.addr[%0d] got %h want %h", i, imem_addr, ea[i]);
      end
      drive(1'b1, 1'b0, psrc[i], 32'h40, word(ea[i]));
      push_exp(knd[i], ea[i]);
      step();
      e = exp_q.pop_front();
      vectors++;
      if ({instruction_id, inced_pc_id, valid_id} !== e) begin
        errors++;
        $display("FAIL redirect.ifid[%0d] got %h/%h/%b want %h/%h/%b", i,
                 instruction_id, inced_pc_id, valid_id, e.ins, e.inc, e.vld);
      end
    end
    vectors++;
    if (imem_addr !== 32'h44) begin
      errors++;
      $display("FAIL redirect.end_addr got %h want 44", imem_addr);
    end
  endtask

  task automatic test_stall_priority();
    logic        rdy[6]  = '{1, 0, 1, 0, 0, 1};
    logic        stl[6]  = '{0, 1, 1, 1, 0, 0};
    logic        psrc[6] = '{0, 1, 1, 1, 1, 0};
    logic [31:0] jpc[6]  = '{32'h0, 32'h80, 32'h80, 32'h80, 32'h43, 32'h0};
    logic        er[6]   = '{1, 1, 1, 0, 0, 1};
    logic [31:0] ea[6]   = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h40};
    int          knd[6]  = '{0, 2, 2, 2, 1, 0};
    exp_t        e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (imem_addr !== ea[i] || imem_req !== er[i]) begin
        errors++;
        $display("FAIL prio.fetch[%0d] got %h/%b want %h/%b", i, imem_addr, imem_req, ea[i], er[i]);
      end
      drive(rdy[i], stl[i], psrc[i], jpc[i], rdy[i] ? word(ea[i]) : 32'hDEAD_BEEF);
      push_exp(knd[i], ea[i]);
      step();
      e = exp_q.pop_front();
      vectors++;
      if ({instruction_id, inced_pc_id, valid_id} !== e) begin
        errors++;
        $display("FAIL prio.ifid[%0d] got %h/%h/%b want %h/%h/%b", i,
                 instruction_id, inced_pc_id, valid_id, e.ins, e.inc, e.vld);
      end
    end
    vectors++;
    if (imem_addr !== 32'h44) begin
      errors++;
      $display("FAIL prio.end_addr got %h want 44", imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    vectors++;
    if (imem_addr2 !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap.first_addr got %h want fffffffc", imem_addr2);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
    step();
    vectors++;
    if ({instruction_id2, inced_pc_id2, valid_id2} !== {32'h1234_5678, 32'h0, 1'b1} || imem_addr2 !== 32'h0) begin
      errors++;
      $display("FAIL wrap.first got %h/%h/%b addr %h want 12345678/0/1 addr 0",
               instruction_id2, inced_pc_id2, valid_id2, imem_addr2);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h9ABC_DEF0);
    step();
    vectors++;
    if ({instruction_id2, inced_pc_id2, valid_id2} !== {32'h9ABC_DEF0, 32'h4, 1'b1}) begin
      errors++;
      $display("FAIL wrap.second got %h/%h/%b want 9abcdef0/4/1",
               instruction_id2, inced_pc_id2, valid_id2);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, word(32'h0));
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0, word(32'h4));
    step();
    vectors++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rstmid.in_hold got req %b want 0", imem_req);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    reset = 1'b0;
    step();
    vectors++;
    if ({instruction_id, inced_pc_id, valid_id} !== 65'h0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid.hold got %h/%h/%b addr %h req %b want 0/0/0 addr 0 req 1",
               instruction_id, inced_pc_id, valid_id, imem_addr, imem_req);
    end
`ifdef IF_PERF_CNT_EN
    vectors++;
    if (fetch_count !== 32'h0 || bubble_count !== 32'h0) begin
      errors++;
      $display("FAIL rstmid.cnt_clear got %0d/%0d want 0/0", fetch_count, bubble_count);
    end
`endif
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, word(32'h0));
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
    step();
`ifdef IF_PERF_CNT_EN
    vectors++;
    if (fetch_count !== 32'd1 || bubble_count !== 32'd1) begin
      errors++;
      $display("FAIL rstmid.cnt got %0d/%0d want 1/1", fetch_count, bubble_count);
    end
`endif
    drive(1'b1, 1'b0, 1'b0, 32'h0, word(32'h4));
    reset = 1'b0;
    step();
    vectors++;
    if (valid_id !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rstmid.wait got vld %b addr %h want 0 0", valid_id, imem_addr);
    end
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, word(32'h0));
    step();
    vectors++;
    if ({instruction_id, inced_pc_id, valid_id} !== {word(32'h0), 32'h4, 1'b1}) begin
      errors++;
      $display("FAIL rstmid.restart got %h/%h/%b want %h/4/1",
               instruction_id, inced_pc_id, valid_id, word(32'h0));
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    last_e = '0;
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect();
    test_stall_priority();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
